// File: rtl/daq_uart_tx.sv
// daq_uart_tx: FIFO-buffered UART transmitter (8N1, LSB first) for the daq_top byte stream.
// Define DAQ_UART_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module daq_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic                        uart_txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        pkt_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef DAQ_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             pkt_done_q, pkt_done_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
`ifdef DAQ_UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [8:0] mem [FIFO_DEPTH];
  logic [8:0] rd_entry;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       baud_end;

  assign s_ready    = (level_q != LEVEL_FULL);
  assign push       = s_valid && s_ready && rst_n;
  assign fifo_empty = (level_q == '0);
  assign baud_end   = (baud_q == BAUD_LAST);
  assign rd_entry   = mem[rd_ptr_q];

  // Storage has no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s_last, s_data};
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    pop        = 1'b0;
    pkt_done_d = 1'b0;
`ifdef DAQ_UART_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef DAQ_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef DAQ_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          pkt_done_d = last_q;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d   = rd_entry[7:0];
      last_d    = rd_entry[8];
      bit_cnt_d = 3'd0;
`ifdef DAQ_UART_PARITY_EN
      parity_d  = ^rd_entry[7:0];
`endif
    end

    // Line level follows the state one cycle later, so the start bit lands two edges after a push.
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef DAQ_UART_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) || !fifo_empty;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
`ifdef DAQ_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
`ifdef DAQ_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign pkt_done   = pkt_done_q;

endmodule
